// File: rtl/layer_3_pool_ctrl_pkg.sv
// Shared types and constants for the layer-3 average-pooling sequencer and its datapath.
package layer_3_pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pool_state_e;

  localparam int unsigned DEF_WIN_BEATS = 4;
  localparam int unsigned DEF_N_WIN     = 25;
  localparam int unsigned POOL_LANES    = 16;
  localparam int unsigned POOL_LANE_W   = 16;
  localparam int unsigned POOL_ACC_W    = 18;

endpackage

// File: rtl/layer_3_pool_ctrl_if.sv
// Beat input and window-result output handshakes of the layer-3 pooling sequencer.
interface layer_3_pool_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/layer_3_pool_ctrl.sv
// Layer-3 pooling sequencer: groups WIN_BEATS beats per window, N_WIN windows per frame.
// Optional LAYER3_POOL_CTRL_LAST_CHECK_EN adds the sticky in_last framing check (err_last).
module layer_3_pool_ctrl
  import layer_3_pool_pkg::*;
#(
  parameter int unsigned WIN_BEATS = DEF_WIN_BEATS,
  parameter int unsigned N_WIN     = DEF_N_WIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  layer_3_pool_ctrl_if.slave       bus,
  output logic                     acc_en,
  output logic                     acc_first,
  output logic                     busy,
  output logic                     frame_done,
  output logic [$clog2(N_WIN)-1:0] win_idx,
  output logic                     err_last
);

  localparam int unsigned BW = $clog2(WIN_BEATS);
  localparam int unsigned WW = $clog2(N_WIN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WIN_BEATS - 1);
  localparam logic [WW-1:0] LAST_WIN  = WW'(N_WIN - 1);

  pool_state_e   state, state_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [WW-1:0] win_nxt;
  logic          in_ready_c;
  logic          out_valid_q;
  logic          handoff;
  logic          last_beat;
  logic          last_win;

  assign last_beat    = (beat_cnt == LAST_BEAT);
  assign last_win     = (win_idx == LAST_WIN);
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_cnt;
    win_nxt    = win_idx;
    in_ready_c = 1'b0;
    acc_en     = 1'b0;
    acc_first  = 1'b0;
    handoff    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          beat_nxt  = '0;
          win_nxt   = '0;
        end
      end
      ACCUM: begin
        in_ready_c = 1'b1;
        acc_en     = bus.in_valid;
        acc_first  = bus.in_valid && (beat_cnt == '0);
        if (bus.in_valid) begin
          if (last_beat) begin
            beat_nxt  = '0;
            state_nxt = HOLD;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          handoff = 1'b1;
          if (last_win) begin
            win_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            win_nxt   = win_idx + 1'b1;
            state_nxt = ACCUM;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      win_idx     <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_nxt;
      win_idx     <= win_nxt;
      out_valid_q <= (state_nxt == HOLD);
      busy        <= (state_nxt != IDLE);
      frame_done  <= handoff && last_win;
    end
  end

`ifdef LAYER3_POOL_CTRL_LAST_CHECK_EN
  logic final_beat;
  assign final_beat = last_beat && last_win;

  // in_last must coincide exactly with the final beat of the final window.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_last <= 1'b0;
    end else if (acc_en && (bus.in_last != final_beat)) begin
      err_last <= 1'b1;
    end
  end
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign err_last       = 1'b0;
`endif

endmodule

// File: tb/tb_layer_3_pool_ctrl.sv
// Directed plus randomized bench for layer_3_pool_ctrl against a beat/handoff counting model.
module tb_layer_3_pool_ctrl;
  localparam int unsigned WB = 4;
  localparam int unsigned NW = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       acc_en, acc_first, busy, frame_done, err_last;
  logic [4:0] win_idx;

  layer_3_pool_ctrl_if bus();

  layer_3_pool_ctrl #(.WIN_BEATS(WB), .N_WIN(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .acc_en     (acc_en),
    .acc_first  (acc_first),
    .busy       (busy),
    .frame_done (frame_done),
    .win_idx    (win_idx),
    .err_last   (err_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: frame described only by beats taken and windows handed off.
  bit m_active;
  int m_beats;
  int m_hands;
  bit m_fdone;
  bit m_err;
  int hs_cnt, fd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hold();
    return m_active && ((m_beats / WB) > m_hands);
  endfunction

  task automatic step(input bit r, input bit s, input bit iv, input bit il, input bit ordy);
    bit e_rdy, e_acc, e_first, e_hold;
    rst = r; start = s;
    bus.in_valid = iv; bus.in_last = il; bus.out_ready = ordy;
    @(negedge clk);
    e_hold  = m_hold();
    e_rdy   = m_active && !e_hold;
    e_acc   = e_rdy && iv;
    e_first = e_acc && ((m_beats % WB) == 0);
    chk("in_ready",   32'(bus.in_ready),  32'(e_rdy));
    chk("acc_en",     32'(acc_en),        32'(e_acc));
    chk("acc_first",  32'(acc_first),     32'(e_first));
    chk("out_valid",  32'(bus.out_valid), 32'(e_hold));
    chk("busy",       32'(busy),          32'(m_active));
    chk("win_idx",    32'(win_idx),       32'(m_hands));
    chk("frame_done", 32'(frame_done),    32'(m_fdone));
    chk("err_last",   32'(err_last),      32'(m_err));
    if (bus.out_valid && ordy) hs_cnt++;
    if (frame_done) fd_cnt++;
    @(posedge clk);
    #1;
    if (r) begin
      m_active = 0; m_beats = 0; m_hands = 0; m_fdone = 0; m_err = 0;
    end else begin
      m_fdone = 0;
      if (!m_active) begin
        if (s) begin
          m_active = 1; m_beats = 0; m_hands = 0;
        end
      end else begin
        if (e_acc) begin
`ifdef LAYER3_POOL_CTRL_LAST_CHECK_EN
          if (il != (m_beats == int'(WB * NW) - 1)) m_err = 1;
`endif
          m_beats++;
        end
        if (e_hold && ordy) begin
          m_hands++;
          if (m_hands == int'(NW)) begin
            m_active = 0; m_hands = 0; m_beats = 0; m_fdone = 1;
          end
        end
      end
    end
  endtask

  function automatic bit good_last();
    return m_beats == int'(WB * NW) - 1;
  endfunction

  task automatic rnd_step();
    bit iv, ordy;
    iv   = ($urandom_range(0, 3) != 0);
    ordy = ($urandom_range(0, 2) != 0);
    step(0, 0, iv, good_last(), ordy);
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 3000 && m_active; i++) rnd_step();
    chk("frame_timeout_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    m_active = 0; m_beats = 0; m_hands = 0; m_fdone = 0; m_err = 0;
    hs_cnt = 0; fd_cnt = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);

    // Back-to-back window with immediate handoff
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("win_idx_after_first", 32'(win_idx), 32'(1));

    // Backpressure in HOLD, with start pulsed during ACCUM
    for (int i = 0; i < 4; i++) step(0, (i == 1), 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0);
    finish_frame();

    // Fresh full frame, random gaps, in_last only on beat 100
    step(0, 1, 0, 0, 0);
    hs_cnt = 0; fd_cnt = 0;
    finish_frame();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
    chk("frame_handshakes", 32'(hs_cnt), 32'(NW));
    chk("frame_done_pulses", 32'(fd_cnt), 32'(1));
    chk("win_idx_after_frame", 32'(win_idx), 32'(0));

    // in_last on beat 50 (sticky error when the check is built in)
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3000 && m_beats < 49; i++) rnd_step();
    for (int i = 0; i < 50 && m_beats == 49; i++) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0), 1);
    finish_frame();

    // Mid-frame reset after beat 2 of window 3
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3000 && m_beats < 15; i++) step(0, 0, ($urandom_range(0, 3) != 0), 0, 1);
    step(1, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_3_pool_ctrl.md
# layer_3_pool_ctrl

Sequencer for the layer-3 16-lane average-pooling datapath. It accepts conv-layer output beats over a valid/ready handshake, groups every WIN_BEATS beats into one pooling window, and drives the datapath's accumulate/load controls. It also presents each window result downstream with backpressure and counts windows to delimit a frame. It sits between the layer-2 conv output stage and the layer-4 input buffer; the parent instantiates the datapath beside it.

## Interface
- WIN_BEATS, 4, beats per pooling window (2x2); power of two, ≥2
- N_WIN, 25, windows per frame (10x10 map → 5x5)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  arm one frame; sampled only in IDLE
- in_valid  in  1  upstream beat valid
- in_ready  out  1  controller accepts beat (beat transfers when in_valid & in_ready)
- in_last  in  1  upstream marks final beat of frame
- acc_en  out  1  datapath adds/loads current i_data this cycle
- acc_first  out  1  with acc_en: datapath loads instead of adds (clears window)
- out_valid  out  1  datapath result stable and valid
- out_ready  in  1  downstream accepts result
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse, final window handed off
- win_idx  out  $clog2(N_WIN)  index of window currently accumulating/presented
- err_last  out  1  sticky framing error (only with LAYER3_POOL_CTRL_LAST_CHECK_EN; else tied 0)

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: in_ready=0; start=1 → ACCUM, beat_cnt=0, win_idx=0, busy=1.
- ACCUM: in_ready=1. acc_en = in_valid & in_ready. acc_first = acc_en & (beat_cnt==0). beat_cnt increments on each transfer. The transfer at beat_cnt==WIN_BEATS-1 → HOLD, beat_cnt=0.
- HOLD: in_ready=0, acc_en=0, out_valid=1. On out_ready:
  - win_idx==N_WIN-1 → win_idx=0, frame_done pulse next cycle, busy=0, IDLE.
  - otherwise → win_idx+1, ACCUM.
- out_valid holds until accepted; it never drops without out_ready. The accumulator is frozen while out_valid=1.
- start while busy is ignored. in_valid in IDLE/HOLD is not consumed.
- Counters are plain binary and wrap only through the explicit compares above. There are no arithmetic datapath widths here; the datapath keeps its 18-bit accumulators, output bits [17:2].

## Timing
- Reset values: state=IDLE, beat_cnt=0, win_idx=0, in_ready=0, acc_en=0, acc_first=0, out_valid=0, busy=0, frame_done=0, err_last=0.
- in_ready, acc_en and acc_first are combinational from state and in_valid. out_valid, busy, frame_done and win_idx are registered.
- Last beat accepted at cycle N → out_valid=1 at N+1 (the datapath register is updated at the edge ending N).
- Peak throughput: one window per WIN_BEATS+1 cycles with out_ready held high.
- out_valid & out_ready at cycle M → in_ready=1 at M+1. The final window sets frame_done=1 at M+1 only.
- Reset mid-frame: all state returns to reset values next cycle. A partial window is discarded because the next window's first beat asserts acc_first.

## Configuration
- LAYER3_POOL_CTRL_LAST_CHECK_EN defined:
  - err_last sets when in_last=1 on any transfer other than the final beat of window N_WIN-1.
  - err_last also sets when that final beat transfers with in_last=0.
  - err_last clears only on rst. Sequencing is unaffected.
- Not defined: in_last is ignored and err_last is constant 0.

## Structure
- Shared package layer_3_pool_pkg: state enum (IDLE/ACCUM/HOLD), default WIN_BEATS/N_WIN constants, lane count 16, lane width 16, accumulator width 18.
- No sub-module: one FSM plus two counters. Datapath instantiation belongs to the parent.

## Test plan
- Reset then start, 4 beats back-to-back, out_ready=1 → acc_first on beat 0 only, out_valid the cycle after beat 3, in_ready back the cycle after handoff, win_idx 0→1.
- out_ready low 7 cycles in HOLD → out_valid steady 7 cycles, in_ready=0, no acc_en despite in_valid=1.
- Full frame of 100 beats, random in_valid gaps → exactly 25 out_valid handshakes, single frame_done after the 25th, busy falls, win_idx=0.
- rst asserted after beat 2 of window 3 → all outputs at reset values; new start plus 4 beats → acc_first on first beat, win_idx=0.
- start pulsed during ACCUM → no effect on counters or state.
- With LAYER3_POOL_CTRL_LAST_CHECK_EN: in_last on beat 50 → err_last=1 and stays 1; in_last on beat 100 only → err_last=0.
